// File: rtl/tx_ds_char_param.sv
// rtl/tx_ds_char_param.sv - dual-rail character transmitter with programmable bit period and NULL fill
module tx_ds_char_param #(
    parameter int DATA_W  = 8,
    parameter int CTRL_W  = 2,
    parameter int BIT_DIV = 1,
    parameter int RZ_GAP  = 1
) (
    input  logic              TxClk,
    input  logic              TxReset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              lchar_i,
    input  logic              idle_null_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              Tx1,
    output logic              Tx0
);

    localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(BIT_DIV - 1);
    localparam logic [BW-1:0]     DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0]     CTRL_LAST = BW'(CTRL_W - 1);
    localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAR,
        S_FLAG,
        S_BITS,
        S_GAP
    } state_t;

    // Holding register: one character buffered ahead of the engine
    logic              hold_full;
    logic              hold_lchar;
    logic [DATA_W-1:0] hold_dat;

    // Engine state
    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              cur_flag, flag_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [BW-1:0]     bit_idx, idx_n;
    logic              acc, acc_n;
    logic              fct_pend, fct_n;
    logic              tx1_n, tx0_n;

    // Combinational helpers
    logic              take;
    logic              sym_end;
    logic              decide;
    logic              start;
    logic              st_flag;
    logic [DATA_W-1:0] st_dat;
    logic [BW-1:0]     last_idx;

    assign ready_o = ~hold_full & ~TxReset;
    assign busy_o  = (state != S_IDLE) | hold_full;

    // Holding register: filled on a handshake, emptied when the engine starts it
    always_ff @(posedge TxClk or posedge TxReset) begin
        if (TxReset) begin
            hold_full  <= 1'b0;
            hold_lchar <= 1'b0;
            hold_dat   <= '0;
        end else if (take) begin
            hold_full  <= 1'b0;
        end else if (valid_i && ready_o) begin
            hold_full  <= 1'b1;
            hold_lchar <= lchar_i;
            hold_dat   <= dat_i;
        end
    end

    // Engine registers, including the registered rail outputs
    always_ff @(posedge TxClk or posedge TxReset) begin
        if (TxReset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_flag <= 1'b0;
            sh       <= '0;
            bit_idx  <= '0;
            acc      <= 1'b0;
            fct_pend <= 1'b0;
            Tx1      <= 1'b0;
            Tx0      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_flag <= flag_n;
            sh       <= sh_n;
            bit_idx  <= idx_n;
            acc      <= acc_n;
            fct_pend <= fct_n;
            Tx1      <= tx1_n;
            Tx0      <= tx0_n;
        end
    end

    // Next-state and next-symbol logic; rails are computed one cycle ahead of their edge
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        flag_n   = cur_flag;
        sh_n     = sh;
        idx_n    = bit_idx;
        acc_n    = acc;
        fct_n    = fct_pend;
        tx1_n    = Tx1;
        tx0_n    = Tx0;
        take     = 1'b0;
        decide   = 1'b0;
        start    = 1'b0;
        st_flag  = 1'b0;
        st_dat   = '0;
        sym_end  = (cnt == CNT_LAST);
        last_idx = cur_flag ? CTRL_LAST : DATA_LAST;

        // The divider only runs while a symbol is on the rails
        if (state != S_IDLE) begin
            cnt_n = sym_end ? '0 : cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                decide = 1'b1;
            end
            S_PAR: begin
                if (sym_end) begin
                    state_n = S_FLAG;
                    tx1_n   = cur_flag;
                    tx0_n   = ~cur_flag;
                end
            end
            S_FLAG: begin
                if (sym_end) begin
                    // First payload bit restarts the parity accumulator
                    state_n = S_BITS;
                    idx_n   = '0;
                    tx1_n   = sh[0];
                    tx0_n   = ~sh[0];
                    acc_n   = sh[0];
                    sh_n    = sh >> 1;
                end
            end
            S_BITS: begin
                if (sym_end) begin
                    if (bit_idx == last_idx) begin
                        if (RZ_GAP != 0) begin
                            state_n = S_GAP;
                            tx1_n   = 1'b0;
                            tx0_n   = 1'b0;
                        end else begin
                            decide = 1'b1;
                        end
                    end else begin
                        idx_n = bit_idx + 1'b1;
                        tx1_n = sh[0];
                        tx0_n = ~sh[0];
                        acc_n = acc ^ sh[0];
                        sh_n  = sh >> 1;
                    end
                end
            end
            S_GAP: begin
                if (sym_end) begin
                    decide = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Character-start decision: a pending FCT keeps NULL atomic, then user data, then NULL fill
        if (decide) begin
            if (fct_pend) begin
                start   = 1'b1;
                st_flag = 1'b1;
                st_dat  = '0;
                fct_n   = 1'b0;
            end else if (hold_full) begin
                start   = 1'b1;
                st_flag = hold_lchar;
                st_dat  = hold_dat;
                take    = 1'b1;
            end else if (idle_null_i) begin
                start   = 1'b1;
                st_flag = 1'b1;
                st_dat  = '1;
                fct_n   = 1'b1;
            end

            if (start) begin
                // acc already holds the parity of every payload bit of the previous character
                state_n = S_PAR;
                flag_n  = st_flag;
                sh_n    = st_flag ? (st_dat & CTRL_MASK) : st_dat;
                tx1_n   = ~(acc ^ st_flag);
                tx0_n   = acc ^ st_flag;
            end else begin
                state_n = S_IDLE;
                tx1_n   = 1'b0;
                tx0_n   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_ds_char_param.sv
// tb/tb_tx_ds_char_param.sv - randomized self-checking bench for tx_ds_char_param
module tb_tx_ds_char_param;

    localparam int DW  = 8;
    localparam int CWD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid;
    logic       lchar;
    logic       inull;
    logic [7:0] dat;
    logic       ready_a, busy_a, tx1_a, tx0_a;
    logic       ready_b, busy_b, tx1_b, tx0_b;

    always #5 clk = ~clk;

    tx_ds_char_param #(.DATA_W(DW), .CTRL_W(CWD), .BIT_DIV(1), .RZ_GAP(1)) u_dut_a (
        .TxClk(clk), .TxReset(rst), .valid_i(valid), .dat_i(dat), .lchar_i(lchar),
        .idle_null_i(inull), .ready_o(ready_a), .busy_o(busy_a), .Tx1(tx1_a), .Tx0(tx0_a)
    );

    tx_ds_char_param #(.DATA_W(DW), .CTRL_W(CWD), .BIT_DIV(4), .RZ_GAP(0)) u_dut_b (
        .TxClk(clk), .TxReset(rst), .valid_i(valid), .dat_i(dat), .lchar_i(lchar),
        .idle_null_i(inull), .ready_o(ready_b), .busy_o(busy_b), .Tx1(tx1_b), .Tx0(tx0_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: each character is expanded into its per-cycle symbol list
    logic [2:0] sym_m [2][64];
    int         len_m [2];
    int         pos_m [2];
    bit         full_m[2];
    bit         hl_m  [2];
    logic [7:0] hd_m  [2];
    bit         par_m [2];
    bit         fct_m [2];
    bit         hs_m  [2];
    logic [1:0] exp_tx[2];
    bit         exp_busy[2];
    bit         exp_ready[2];

    logic [1:0] hist_a[$];
    logic [1:0] hist_b[$];

    function automatic int bdiv_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            len_m[i] = 0; pos_m[i] = 0; full_m[i] = 0; hl_m[i] = 0;
            hd_m[i] = 0; par_m[i] = 0; fct_m[i] = 0; hs_m[i] = 0;
        end
    endtask

    task automatic add_sym(input int i, input logic [2:0] s);
        for (int r = 0; r < bdiv_of(i); r++) begin
            sym_m[i][len_m[i]] = s;
            len_m[i]++;
        end
    endtask

    task automatic model_edge(input int i);
        bit         have, fl, take, p;
        logic [7:0] pl;
        logic [2:0] cur;
        int         n;
        have = 0; take = 0; fl = 0; pl = 8'h00;
        if (pos_m[i] >= len_m[i]) begin
            len_m[i] = 0; pos_m[i] = 0;
            if (fct_m[i]) begin
                have = 1; fl = 1; pl = 8'h00; fct_m[i] = 0;
            end else if (full_m[i]) begin
                have = 1; fl = hl_m[i]; pl = hd_m[i]; take = 1;
            end else if (inull) begin
                have = 1; fl = 1; pl = 8'hFF; fct_m[i] = 1;
            end
            if (have) begin
                n = fl ? CWD : DW;
                p = ~(par_m[i] ^ fl);
                add_sym(i, {1'b1, p, ~p});
                add_sym(i, {1'b1, fl, ~fl});
                par_m[i] = 0;
                for (int b = 0; b < n; b++) begin
                    add_sym(i, {1'b1, pl[b], ~pl[b]});
                    par_m[i] = par_m[i] ^ pl[b];
                end
                if (i == 0) add_sym(i, 3'b100);
            end
        end
        if (pos_m[i] < len_m[i]) begin
            cur = sym_m[i][pos_m[i]];
            pos_m[i]++;
        end else begin
            cur = 3'b000;
        end
        hs_m[i] = valid && !full_m[i];
        if (take) full_m[i] = 0;
        else if (hs_m[i]) begin
            full_m[i] = 1; hl_m[i] = lchar; hd_m[i] = dat;
        end
        exp_tx[i]    = cur[1:0];
        exp_busy[i]  = cur[2] | full_m[i];
        exp_ready[i] = !full_m[i];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        chk("tx_a",    {tx1_a, tx0_a}, exp_tx[0]);
        chk("ready_a", ready_a,        exp_ready[0]);
        chk("busy_a",  busy_a,         exp_busy[0]);
        chk("tx_b",    {tx1_b, tx0_b}, exp_tx[1]);
        chk("ready_b", ready_b,        exp_ready[1]);
        chk("busy_b",  busy_b,         exp_busy[1]);
        hist_a.push_back({tx1_a, tx0_a});
        hist_b.push_back({tx1_b, tx0_b});
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_tx_a"},    {tx1_a, tx0_a}, 2'b00);
        chk({tag, "_ready_a"}, ready_a,        1'b0);
        chk({tag, "_busy_a"},  busy_a,         1'b0);
        chk({tag, "_tx_b"},    {tx1_b, tx0_b}, 2'b00);
        chk({tag, "_ready_b"}, ready_b,        1'b0);
        chk({tag, "_busy_b"},  busy_b,         1'b0);
    endtask

    // Called between edges so that reset lands asynchronously
    task automatic do_reset(input int n);
        valid = 0;
        rst   = 1;
        #1;
        rst_checks("rst_async");
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst_checks("rst_hold");
        end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic wait_hs_a(input string tag);
        int guard;
        guard = 0;
        tick();
        while (!hs_m[0] && guard < 100) begin
            tick();
            guard++;
        end
        if (!hs_m[0]) chk({tag, "_hs_timeout"}, 0, 1);
    endtask

    logic [1:0] ea [17];
    logic [1:0] eb [14];
    logic [1:0] en [22];
    logic [1:0] e;
    int k, kb;

    initial begin
        ea = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00,
               2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
        eb = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10,
               2'b01, 2'b10, 2'b10, 2'b01};
        en = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00,
               2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
        valid = 0; lchar = 0; dat = 8'h00; inull = 0;
        model_reset();
        @(negedge clk);
        do_reset(3);
        repeat (3) tick();

        // Data 0xA5 followed immediately by control 0x01
        valid = 1; dat = 8'hA5; lchar = 0;
        tick();
        k  = hist_a.size() - 1;
        kb = hist_b.size() - 1;
        dat = 8'h01; lchar = 1;
        wait_hs_a("ctl01");
        valid = 0;
        repeat (60) tick();
        for (int j = 0; j < 17; j++)
            chk($sformatf("a5_seq_a[%0d]", j), hist_a[k + 1 + j], ea[j]);
        for (int j = 0; j < 58; j++) begin
            e = (j < 56) ? eb[j / 4] : 2'b00;
            chk($sformatf("a5_seq_b[%0d]", j), hist_b[kb + 1 + j], e);
        end

        // NULL fill from a clean reset; a user character offered during ESC waits for FCT
        do_reset(3);
        tick();
        inull = 1;
        tick();
        k = hist_a.size() - 1;
        valid = 1; dat = 8'h3C; lchar = 0;
        tick();
        valid = 0; inull = 0;
        repeat (70) tick();
        for (int j = 0; j < 22; j++)
            chk($sformatf("null_seq_a[%0d]", j), hist_a[k + j], en[j]);

        // Reset during payload bit 3, then parity must restart from zero
        tick();
        valid = 1; dat = 8'hFF; lchar = 0;
        tick();
        valid = 0;
        repeat (6) tick();
        do_reset(3);
        tick();
        valid = 1; dat = 8'h00; lchar = 0;
        tick();
        valid = 0;
        tick();
        chk("par_after_reset_a", hist_a[hist_a.size() - 1], 2'b10);
        repeat (60) tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            valid = ($urandom_range(0, 2) != 0);
            dat   = 8'($urandom());
            lchar = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) inull = ~inull;
            tick();
        end
        valid = 0; inull = 0;
        repeat (80) tick();
        chk("drain_busy_a", busy_a, 1'b0);
        chk("drain_busy_b", busy_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
